// File: rtl/modular_inverse_if.sv
// Stream bundle for the modular inverse core: operand and modulus in, result out.
//
// Handshake rule for every channel below: a beat transfers on a rising clk edge
// where tvalid and tready are both high. Once tvalid is raised, the source holds
// tvalid and tdata (and tuser) until that edge. tready carries no obligation.
interface modular_inverse_if #(
  parameter int SIZE = 64
);
  logic [SIZE-1:0] input_operand_tdata;
  logic            input_operand_tvalid;
  logic            input_operand_tready;

  logic [SIZE-1:0] input_modulus_tdata;
  logic            input_modulus_tvalid;
  logic            input_modulus_tready;

  logic [SIZE-1:0] output_tdata;
  logic            output_tuser;
  logic            output_tvalid;
  logic            output_tready;

  // Current FSM state, brought out for observation: 0=IDLE 1=RUN 2=DONE.
  logic [1:0]      dbg_state;

  // Core side.
  modport slave (
    input  input_operand_tdata,
    input  input_operand_tvalid,
    output input_operand_tready,
    input  input_modulus_tdata,
    input  input_modulus_tvalid,
    output input_modulus_tready,
    output output_tdata,
    output output_tuser,
    output output_tvalid,
    input  output_tready,
    output dbg_state
  );

  // Producer / consumer side.
  modport master (
    output input_operand_tdata,
    output input_operand_tvalid,
    input  input_operand_tready,
    output input_modulus_tdata,
    output input_modulus_tvalid,
    input  input_modulus_tready,
    input  output_tdata,
    input  output_tuser,
    input  output_tvalid,
    output output_tready,
    input  dbg_state
  );
endinterface

// File: rtl/modular_inverse.sv
// Modular inverse x = a^-1 mod p via the binary extended Euclidean algorithm,
// one reduction step per clock. Used to divide by the shared secret in the
// ElGamal decryption path. Result is 0 with tuser=1 when no inverse exists or
// the operands are illegal (p even, p<3, a==0, a>=p).
module modular_inverse #(
  parameter int SIZE = 64
) (
  input  logic           clk,
  input  logic           rst,
  modular_inverse_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [SIZE-1:0] u_q;
  logic [SIZE-1:0] v_q;
  logic [SIZE-1:0] p_q;
  // One extra bit so x+p fits before the halving shift.
  logic [SIZE:0]   x1_q;
  logic [SIZE:0]   x2_q;
  logic [SIZE-1:0] tdata_q;
  logic            tuser_q;
  logic            tvalid_q;

  logic [SIZE-1:0] a_in;
  logic [SIZE-1:0] p_in;
  logic            in_ready;
  logic            capture;
  logic            op_illegal;

  logic [SIZE:0]   p_ext;
  logic [SIZE:0]   x1_half;
  logic [SIZE:0]   x2_half;
  logic [SIZE:0]   x1_sub;
  logic [SIZE:0]   x2_sub;
  logic            u_one;
  logic            v_one;
  logic            u_zero;
  logic            v_zero;
  logic            u_ge_v;

  assign a_in = bus.input_operand_tdata;
  assign p_in = bus.input_modulus_tdata;

  // Inputs are only offered while idle; both channels must be valid together.
  assign in_ready = (state_q == IDLE) && !rst;
  assign capture  = in_ready && bus.input_operand_tvalid && bus.input_modulus_tvalid;

  assign bus.input_operand_tready = in_ready;
  assign bus.input_modulus_tready = in_ready;
  assign bus.output_tdata         = tdata_q;
  assign bus.output_tuser         = tuser_q;
  assign bus.output_tvalid        = tvalid_q;
  assign bus.dbg_state            = state_q;

  // Operand legality: modulus must be odd and at least 3, a must lie in [1,p).
  assign op_illegal = !p_in[0] || (p_in < SIZE'(3)) || (a_in == '0) || (a_in >= p_in);

  assign p_ext  = {1'b0, p_q};
  assign u_one  = (u_q == SIZE'(1));
  assign v_one  = (v_q == SIZE'(1));
  assign u_zero = (u_q == '0);
  assign v_zero = (v_q == '0);
  assign u_ge_v = (u_q >= v_q);

  // Coefficient updates: halve mod p (add p first when odd) and subtract mod p.
  // All x values stay in [0,p), so x+p never exceeds SIZE+1 bits.
  always_comb begin
    x1_half = x1_q[0] ? ((x1_q + p_ext) >> 1) : (x1_q >> 1);
    x2_half = x2_q[0] ? ((x2_q + p_ext) >> 1) : (x2_q >> 1);
    x1_sub  = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q + p_ext - x2_q);
    x2_sub  = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q + p_ext - x1_q);
  end

  // Control FSM and datapath registers; exactly one reduction action per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      p_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture) begin
            p_q <= p_in;
            if (op_illegal) begin
              tdata_q  <= '0;
              tuser_q  <= 1'b1;
              tvalid_q <= 1'b1;
              state_q  <= DONE;
            end else begin
              u_q     <= a_in;
              v_q     <= p_in;
              x1_q    <= (SIZE+1)'(1);
              x2_q    <= '0;
              state_q <= RUN;
            end
          end
        end

        RUN: begin
          if (u_one) begin
            tdata_q  <= x1_q[SIZE-1:0];
            tuser_q  <= 1'b0;
            tvalid_q <= 1'b1;
            state_q  <= DONE;
          end else if (v_one) begin
            tdata_q  <= x2_q[SIZE-1:0];
            tuser_q  <= 1'b0;
            tvalid_q <= 1'b1;
            state_q  <= DONE;
          end else if (u_zero || v_zero) begin
            // gcd(a,p) > 1: no inverse.
            tdata_q  <= '0;
            tuser_q  <= 1'b1;
            tvalid_q <= 1'b1;
            state_q  <= DONE;
          end else if (!u_q[0]) begin
            u_q  <= u_q >> 1;
            x1_q <= x1_half;
          end else if (!v_q[0]) begin
            v_q  <= v_q >> 1;
            x2_q <= x2_half;
          end else if (u_ge_v) begin
            u_q  <= u_q - v_q;
            x1_q <= x1_sub;
          end else begin
            v_q  <= v_q - u_q;
            x2_q <= x2_sub;
          end
        end

        DONE: begin
          // Result held stable until the consumer takes it.
          if (bus.output_tready) begin
            tvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modular_inverse.sv
// Directed bench for modular_inverse: vector table plus handshake/reset sequences.
module tb_modular_inverse;
  localparam int SIZE    = 64;
  localparam int MAX_LAT = 4 * SIZE + 2;

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] p;
    logic [SIZE-1:0] x;
    logic            err;
    int              lat;  // exact latency required, 0 = only the upper bound
    string           name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  logic [SIZE:0] exp_q[$];

  // Clock and DUT.
  always #5 clk = ~clk;

  modular_inverse_if #(.SIZE(SIZE)) bus ();

  modular_inverse #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [SIZE-1:0] a, input logic [SIZE-1:0] p,
                         input logic [SIZE-1:0] x, input logic err, input int lat,
                         input string name);
    vec_t v;
    v.a = a; v.p = p; v.x = x; v.err = err; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  // Present a and p together from a falling edge; returns at the falling edge
  // after the capturing rising edge, with valids dropped.
  task automatic capture(input logic [SIZE-1:0] a, input logic [SIZE-1:0] p, output bit ok);
    int n;
    bus.input_operand_tdata  = a;
    bus.input_modulus_tdata  = p;
    bus.input_operand_tvalid = 1'b1;
    bus.input_modulus_tvalid = 1'b1;
    n = 0;
    while (!(bus.input_operand_tready && bus.input_modulus_tready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 50);
    @(posedge clk);
    @(negedge clk);
    bus.input_operand_tvalid = 1'b0;
    bus.input_modulus_tvalid = 1'b0;
  endtask

  // Latency counts the capture cycle as cycle 1.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.output_tvalid && lat < MAX_LAT + 5) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int lat;
    logic [SIZE:0] exp;
    exp_q.push_back({v.err, v.x});
    capture(v.a, v.p, ok);
    check({v.name, " accept"}, 128'(ok), 128'(1));
    wait_result(lat);
    check({v.name, " tvalid"}, 128'(bus.output_tvalid), 128'(1));
    exp = exp_q.pop_front();
    check({v.name, " tdata"}, 128'(bus.output_tdata), 128'(exp[SIZE-1:0]));
    check({v.name, " tuser"}, 128'(bus.output_tuser), 128'(exp[SIZE]));
    if (v.lat != 0) check({v.name, " latency"}, 128'(lat), 128'(v.lat));
    else            check({v.name, " latency_bound"}, 128'(lat <= MAX_LAT), 128'(1));
    // output_tready is high, so the handshake completes on the next edge.
    @(negedge clk);
    check({v.name, " tvalid_drop"}, 128'(bus.output_tvalid), 128'(0));
    check({v.name, " idle_ready"}, 128'(bus.input_operand_tready), 128'(1));
  endtask

  initial begin
    bit ok;
    int lat;
    bit seen;

    add_vec(64'd3,  64'd7,  64'd5,  1'b0, 0, "inv_3_7");
    add_vec(64'd1,  64'd13, 64'd1,  1'b0, 2, "inv_1_13");
    add_vec(64'd12, 64'd13, 64'd12, 1'b0, 0, "inv_12_13");
    add_vec(64'd2,  64'hFFFF_FFFF_FFFF_FFC5, 64'h7FFF_FFFF_FFFF_FFE3, 1'b0, 0, "inv_2_big");
    add_vec(64'd5,  64'd11, 64'd9,  1'b0, 0, "inv_5_11");
    add_vec(64'd10, 64'd17, 64'd12, 1'b0, 0, "inv_10_17");
    add_vec(64'd7,  64'd9,  64'd4,  1'b0, 0, "inv_7_9");
    add_vec(64'd0,  64'd7,  64'd0,  1'b1, 1, "err_a0");
    add_vec(64'd7,  64'd7,  64'd0,  1'b1, 1, "err_a_eq_p");
    add_vec(64'd9,  64'd7,  64'd0,  1'b1, 1, "err_a_gt_p");
    add_vec(64'd5,  64'd8,  64'd0,  1'b1, 1, "err_p_even");
    add_vec(64'd1,  64'd1,  64'd0,  1'b1, 1, "err_p_small");
    add_vec(64'd6,  64'd9,  64'd0,  1'b1, 0, "err_gcd3");

    // Reset, with inputs offered throughout: nothing may be taken.
    rst = 1'b1;
    bus.input_operand_tdata  = 64'd3;
    bus.input_modulus_tdata  = 64'd7;
    bus.input_operand_tvalid = 1'b1;
    bus.input_modulus_tvalid = 1'b1;
    bus.output_tready        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 128'(bus.dbg_state), 128'(0));
    check("rst_tvalid", 128'(bus.output_tvalid), 128'(0));
    check("rst_tdata", 128'(bus.output_tdata), 128'(0));
    check("rst_tuser", 128'(bus.output_tuser), 128'(0));
    check("rst_op_tready", 128'(bus.input_operand_tready), 128'(0));
    check("rst_mod_tready", 128'(bus.input_modulus_tready), 128'(0));
    bus.input_operand_tvalid = 1'b0;
    bus.input_modulus_tvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 128'(bus.dbg_state), 128'(0));

    // Vector table.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Lone operand valid: ready is shown but nothing transfers.
    bus.input_operand_tdata  = 64'd3;
    bus.input_operand_tvalid = 1'b1;
    bus.input_modulus_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lone_op_tready", 128'(bus.input_operand_tready), 128'(1));
      check("lone_op_state", 128'(bus.dbg_state), 128'(0));
    end
    bus.input_modulus_tdata  = 64'd7;
    bus.input_modulus_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.input_operand_tvalid = 1'b0;
    bus.input_modulus_tvalid = 1'b0;
    check("lone_capture_run", 128'(bus.dbg_state), 128'(1));
    wait_result(lat);
    check("lone_tvalid", 128'(bus.output_tvalid), 128'(1));
    check("lone_tdata", 128'(bus.output_tdata), 128'(5));
    @(negedge clk);

    // Backpressure: result held for 20 cycles, inputs blocked.
    bus.output_tready = 1'b0;
    capture(64'd5, 64'd11, ok);
    check("bp_accept", 128'(ok), 128'(1));
    wait_result(lat);
    check("bp_tvalid", 128'(bus.output_tvalid), 128'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_tvalid", 128'(bus.output_tvalid), 128'(1));
      check("bp_hold_tdata", 128'(bus.output_tdata), 128'(9));
      check("bp_hold_tuser", 128'(bus.output_tuser), 128'(0));
      check("bp_hold_tready", 128'({bus.input_operand_tready, bus.input_modulus_tready}), 128'(0));
    end
    bus.output_tready = 1'b1;
    @(negedge clk);
    check("bp_release_tvalid", 128'(bus.output_tvalid), 128'(0));
    check("bp_release_idle", 128'(bus.dbg_state), 128'(0));
    @(negedge clk);
    check("bp_single_beat", 128'(bus.output_tvalid), 128'(0));

    // Reset pulse mid-RUN abandons the job.
    capture(64'd3, 64'd7, ok);
    check("rr_accept", 128'(ok), 128'(1));
    check("rr_in_run", 128'(bus.dbg_state), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rr_idle", 128'(bus.dbg_state), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.output_tvalid) seen = 1'b1;
    end
    check("rr_no_output", 128'(seen), 128'(0));
    run_vec('{a: 64'd4, p: 64'd7, x: 64'd2, err: 1'b0, lat: 0, name: "rr_fresh_4_7"});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modular_inverse.md
Name: modular_inverse

Overview:
- Computes x = a^-1 mod p, where x*a ≡ 1 (mod p), using the binary extended Euclidean algorithm with one iteration step per clock.
- This is the undo operation for the modular multiplier. The ElGamal decryption datapath uses it to divide by the shared secret s = c1^x mod p.
- Operands enter and the result leaves on AXI-stream style valid/ready ports, in the same style as the other arithmetic cores.

Parameters:
- SIZE, 64, width of operand, modulus and result in bits.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- input_operand_tdata  input  SIZE  value a to invert
- input_operand_tvalid  input  1  operand valid
- input_operand_tready  output  1  operand accepted when high with tvalid
- input_modulus_tdata  input  SIZE  modulus p
- input_modulus_tvalid  input  1  modulus valid
- input_modulus_tready  output  1  modulus accepted when high with tvalid
- output_tdata  output  SIZE  inverse x, 0 on error
- output_tuser  output  1  error flag: no inverse exists or operands illegal
- output_tvalid  output  1  result valid
- output_tready  input  1  downstream accepts result

Behaviour:
- Reset values: state IDLE, output_tdata=0, output_tuser=0, output_tvalid=0, both input treadys=0 during rst.
- States: IDLE, RUN, DONE.
- IDLE:
  - Both input treadys are high in IDLE only (and not rst).
  - Capture happens only when both tvalids are high in the same cycle; a lone tvalid is not consumed.
- On capture, the operands are checked:
  - Error if p even, p<3, a==0, or a>=p. Go to DONE with tdata=0, tuser=1.
  - Otherwise load u=a, v=p, x1=1, x2=0 and go to RUN.
- x1 and x2 are SIZE+1 bits wide internally, to hold x+p before halving. All x values stay in [0,p).
- RUN performs exactly one action per cycle, in this priority:
  1. u==1: result=x1, go to DONE, tuser=0.
  2. v==1: result=x2, go to DONE, tuser=0.
  3. u==0 or v==0 (gcd>1): go to DONE, tdata=0, tuser=1.
  4. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+p)>>1.
  5. v even: v=v>>1; x2 updated the same way.
  6. u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1+p-x2.
  7. Otherwise: v=v-u; x2 = x2>=x1 ? x2-x1 : x2+p-x1.
- Latency from capture to output_tvalid is at most 4*SIZE+2 cycles. The error path at capture takes 1 cycle.
- DONE:
  - output_tvalid=1 and tdata/tuser are held stable until output_tready=1.
  - On handshake, output_tvalid drops the next cycle and the state returns to IDLE.
  - New inputs are not accepted before that, so there is no overlap.
- output_tready has no effect outside DONE.
- rst mid-RUN or mid-DONE: the state is abandoned with no output and all registers return to reset values. An input presented during rst is not captured.
- Result is always < p. For a==1 the result is 1 on the first RUN cycle.

Test Plan:
- a=3, p=7, output_tready=1 -> output_tdata=5, tuser=0, one output_tvalid pulse; next input accepted in the IDLE cycle after.
- a=1, p=13 -> tdata=1 two cycles after capture. a=12, p=13 -> tdata=12. a=2, p=2^64-59 -> tdata=2^63-29, within 4*SIZE+2 cycles.
- Errors, each -> tdata=0, tuser=1:
  - a=0, p=7
  - a=7, p=7
  - a=5, p=8
  - a=6, p=9 (gcd 3, error found in RUN)
- Only operand_tvalid=1 for 5 cycles, then modulus_tvalid raised -> capture only on the cycle both are high; operand tready seen with no transfer.
- output_tready held low 20 cycles after tvalid -> tdata/tuser/tvalid stable, input treadys low; release -> single handshake, return to IDLE.
- Assert rst for 1 cycle mid-RUN on a=3, p=7 -> no output_tvalid; a fresh a=4, p=7 then yields 2.
